vx_csr_access_unit: RTL and testbench

//  Per-core CSR instruction executor sitting between the issue/dispatch stage and the CSR data

---
 rtl/vx_csr_access_unit.sv | 152 +++++++++++++++
 tb/tb_vx_csr_access_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_csr_access_unit.sv
// CSR instruction executor: reads the old CSR value in the accept cycle,
// computes the CSRRW/CSRRS/CSRRC result, holds it in a one-entry output
// stage, issues one write pulse and returns the old value to writeback.
module vx_csr_access_unit #(
    parameter int CORE_ID       = 0,
    parameter int UUID_BITS     = 8,
    parameter int NW_BITS       = 2,
    parameter int CSR_ADDR_BITS = 12
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [UUID_BITS-1:0]     req_uuid,
    input  logic [NW_BITS-1:0]       req_wid,
    input  logic [1:0]               req_op,
    input  logic [CSR_ADDR_BITS-1:0] req_addr,
    input  logic [31:0]              req_src,
    input  logic                     req_no_write,

    output logic                     csr_read_enable,
    output logic [UUID_BITS-1:0]     csr_read_uuid,
    output logic [CSR_ADDR_BITS-1:0] csr_read_addr,
    output logic [NW_BITS-1:0]       csr_read_wid,
    input  logic [31:0]              csr_read_data,

    output logic                     csr_write_enable,
    output logic [UUID_BITS-1:0]     csr_write_uuid,
    output logic [CSR_ADDR_BITS-1:0] csr_write_addr,
    output logic [NW_BITS-1:0]       csr_write_wid,
    output logic [31:0]              csr_write_data,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [UUID_BITS-1:0]     rsp_uuid,
    output logic [NW_BITS-1:0]       rsp_wid,
    output logic [31:0]              rsp_data,

    output logic                     busy
);

    localparam logic [1:0] OP_RW = 2'd1;
    localparam logic [1:0] OP_RS = 2'd2;
    localparam logic [1:0] OP_RC = 2'd3;

    // S1 control state (reset) and payload (load-only)
    logic                     s1_valid_q, s1_valid_d;
    logic                     wr_pend_q,  wr_pend_d;
    logic [UUID_BITS-1:0]     s1_uuid_q,  s1_uuid_d;
    logic [NW_BITS-1:0]       s1_wid_q,   s1_wid_d;
    logic [CSR_ADDR_BITS-1:0] s1_addr_q,  s1_addr_d;
    logic [31:0]              s1_old_q,   s1_old_d;
    logic [31:0]              s1_new_q,   s1_new_d;

    logic        hazard;
    logic        accept;
    logic        we;
    logic [31:0] new_value;

    // Accept logic and read-modify-write computation for the offered request
    always_comb begin
        // A write still pending to the same CSR of the same warp must commit
        // before the read, so the retried read observes the new value.
        hazard    = wr_pend_q & (req_addr == s1_addr_q) & (req_wid == s1_wid_q);
        req_ready = ~reset & (~s1_valid_q | rsp_ready) & ~hazard;
        accept    = req_valid & req_ready;

        // Illegal op 0 falls through to the set form, but never writes.
        unique case (req_op)
            OP_RW:   new_value = req_src;
            OP_RC:   new_value = csr_read_data & ~req_src;
            default: new_value = csr_read_data | req_src;
        endcase
        // RW always writes; RS/RC skip the write when the source is x0.
        we = (req_op == OP_RW) | ((req_op != 2'd0) & ~req_no_write);
    end

    // Next state of the output stage: load on accept, drain on handshake
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_uuid_d  = s1_uuid_q;
        s1_wid_d   = s1_wid_q;
        s1_addr_d  = s1_addr_q;
        s1_old_d   = s1_old_q;
        s1_new_d   = s1_new_q;
        // The write pulse lives only in the first S1 cycle of an instruction.
        wr_pend_d  = accept & we;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_uuid_d  = req_uuid;
            s1_wid_d   = req_wid;
            s1_addr_d  = req_addr;
            s1_old_d   = csr_read_data;
            s1_new_d   = new_value;
        end else if (rsp_valid && rsp_ready) begin
            s1_valid_d = 1'b0;
        end
    end

    // Control registers; reset discards S1 and any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            wr_pend_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            wr_pend_q  <= wr_pend_d;
        end
    end

    // Payload registers; contents are meaningful only while s1_valid_q is set
    always_ff @(posedge clk) begin
        s1_uuid_q <= s1_uuid_d;
        s1_wid_q  <= s1_wid_d;
        s1_addr_q <= s1_addr_d;
        s1_old_q  <= s1_old_d;
        s1_new_q  <= s1_new_d;
    end

    // Read port mirrors the request; write and response ports come from S1
    always_comb begin
        csr_read_enable  = accept;
        csr_read_uuid    = req_uuid;
        csr_read_addr    = req_addr;
        csr_read_wid     = req_wid;

        csr_write_enable = s1_valid_q & wr_pend_q & ~reset;
        csr_write_uuid   = s1_uuid_q;
        csr_write_addr   = s1_addr_q;
        csr_write_wid    = s1_wid_q;
        csr_write_data   = s1_new_q;

        rsp_valid        = s1_valid_q & ~reset;
        rsp_uuid         = s1_uuid_q;
        rsp_wid          = s1_wid_q;
        rsp_data         = s1_old_q;

        busy             = (req_valid | s1_valid_q) & ~reset;
    end

`ifndef SYNTHESIS
    // Flag illegal op 0 in simulation
    always_ff @(posedge clk) begin
        if (!reset && req_valid && req_ready) begin
            assert (req_op != 2'd0)
                else $error("vx_csr_access_unit[%0d]: illegal CSR op 0", CORE_ID);
        end
    end
`endif

endmodule

// File: tb/tb_vx_csr_access_unit.sv
// Directed bench for vx_csr_access_unit with a small CSR storage model.
module tb_vx_csr_access_unit;

    localparam int UB = 8;
    localparam int NB = 2;
    localparam int AB = 12;
    localparam logic [1:0] OP_RW = 2'd1;
    localparam logic [1:0] OP_RS = 2'd2;
    localparam logic [1:0] OP_RC = 2'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_no_write;
    logic [UB-1:0] req_uuid;
    logic [NB-1:0] req_wid;
    logic [1:0]    req_op;
    logic [AB-1:0] req_addr;
    logic [31:0]   req_src;
    logic          csr_read_enable;
    logic [UB-1:0] csr_read_uuid;
    logic [AB-1:0] csr_read_addr;
    logic [NB-1:0] csr_read_wid;
    logic [31:0]   csr_read_data;
    logic          csr_write_enable;
    logic [UB-1:0] csr_write_uuid;
    logic [AB-1:0] csr_write_addr;
    logic [NB-1:0] csr_write_wid;
    logic [31:0]   csr_write_data;
    logic          rsp_valid, rsp_ready;
    logic [UB-1:0] rsp_uuid;
    logic [NB-1:0] rsp_wid;
    logic [31:0]   rsp_data;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // CSR storage model: slot = {wid[0], addr[1:0]}
    logic [31:0] mem [0:7];
    int          wr_count = 0;
    logic        pl_en = 1'b0;
    logic [2:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    assign csr_read_data = mem[{csr_read_wid[0], csr_read_addr[1:0]}];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (csr_write_enable) begin
            mem[{csr_write_wid[0], csr_write_addr[1:0]}] <= csr_write_data;
            wr_count <= wr_count + 1;
        end
    end

    always #5 clk = ~clk;

    vx_csr_access_unit #(.CORE_ID(0), .UUID_BITS(UB), .NW_BITS(NB), .CSR_ADDR_BITS(AB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid),
        .req_wid(req_wid), .req_op(req_op), .req_addr(req_addr),
        .req_src(req_src), .req_no_write(req_no_write),
        .csr_read_enable(csr_read_enable), .csr_read_uuid(csr_read_uuid),
        .csr_read_addr(csr_read_addr), .csr_read_wid(csr_read_wid),
        .csr_read_data(csr_read_data),
        .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid),
        .csr_write_addr(csr_write_addr), .csr_write_wid(csr_write_wid),
        .csr_write_data(csr_write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid),
        .rsp_wid(rsp_wid), .rsp_data(rsp_data),
        .busy(busy)
    );

    task automatic preload(input logic [2:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_data = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] op, input logic [AB-1:0] addr,
                           input logic [NB-1:0] wid, input logic [31:0] src,
                           input logic nw, input logic [UB-1:0] uuid);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wid = wid;
        req_src = src; req_no_write = nw; req_uuid = uuid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rsp_ready = 1'b1;
        set_req(OP_RW, 12'h340, 2'd0, 32'h1, 1'b0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({rsp_valid, csr_write_enable, csr_read_enable, busy, req_ready} !== 5'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: got %b want 00000", i,
                         {rsp_valid, csr_write_enable, csr_read_enable, busy, req_ready});
            end
        end
        reset = 1'b0;
        req_valid = 1'b0;
        @(posedge clk); #1;
        $display("[TB] test_reset done");
    endtask

    task automatic test_rw();
        int w0;
        preload(3'd0, 32'h0000_1234);
        w0 = wr_count;
        rsp_ready = 1'b1;
        set_req(OP_RW, 12'h340, 2'd0, 32'hDEAD_BEEF, 1'b0, 8'h11);
        #1;
        tests_run++;
        if ({req_ready, csr_read_enable, rsp_valid} !== 3'b110) begin
            tests_failed++;
            $display("FAIL rw_accept: ready/rd_en/rsp_valid got %b want 110",
                     {req_ready, csr_read_enable, rsp_valid});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        tests_run++;
        if ({rsp_valid, rsp_data, rsp_uuid} !== {1'b1, 32'h0000_1234, 8'h11}) begin
            tests_failed++;
            $display("FAIL rw_rsp: got v=%b d=%h u=%h want v=1 d=00001234 u=11",
                     rsp_valid, rsp_data, rsp_uuid);
        end
        tests_run++;
        if ({csr_write_enable, csr_write_data, csr_write_addr} !== {1'b1, 32'hDEAD_BEEF, 12'h340}) begin
            tests_failed++;
            $display("FAIL rw_write: got en=%b d=%h a=%h want en=1 d=deadbeef a=340",
                     csr_write_enable, csr_write_data, csr_write_addr);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({rsp_valid, csr_write_enable} !== 2'b00 || wr_count - w0 != 1) begin
            tests_failed++;
            $display("FAIL rw_after: v=%b we=%b writes=%0d want 0 0 1",
                     rsp_valid, csr_write_enable, wr_count - w0);
        end
        $display("[TB] test_rw done");
    endtask

    task automatic test_set_clear();
        int w0;
        preload(3'd1, 32'h0F0);
        preload(3'd2, 32'h0FF);
        preload(3'd3, 32'h055);
        w0 = wr_count;
        rsp_ready = 1'b1;
        set_req(OP_RS, 12'h341, 2'd0, 32'h00F, 1'b0, 8'h12);
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rs_accept: req_ready got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        set_req(OP_RC, 12'h342, 2'd0, 32'h00F, 1'b0, 8'h13);
        #1;
        tests_run++;
        if ({req_ready, rsp_data, csr_write_enable, csr_write_data} !== {1'b1, 32'h0F0, 1'b1, 32'h0FF}) begin
            tests_failed++;
            $display("FAIL rs_result: rdy=%b rsp=%h we=%b wd=%h want 1 000000f0 1 000000ff",
                     req_ready, rsp_data, csr_write_enable, csr_write_data);
        end
        @(posedge clk); #1;
        set_req(OP_RS, 12'h343, 2'd0, 32'h0FF, 1'b1, 8'h14);
        #1;
        tests_run++;
        if ({rsp_data, csr_write_enable, csr_write_data} !== {32'h0FF, 1'b1, 32'h0F0}) begin
            tests_failed++;
            $display("FAIL rc_result: rsp=%h we=%b wd=%h want 000000ff 1 000000f0",
                     rsp_data, csr_write_enable, csr_write_data);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        tests_run++;
        if ({rsp_valid, rsp_data, csr_write_enable} !== {1'b1, 32'h055, 1'b0}) begin
            tests_failed++;
            $display("FAIL rs_nowrite: v=%b rsp=%h we=%b want 1 00000055 0",
                     rsp_valid, rsp_data, csr_write_enable);
        end
        @(posedge clk); #1;
        tests_run++;
        if (wr_count - w0 != 2) begin
            tests_failed++;
            $display("FAIL setclr_write_count: got %0d want 2", wr_count - w0);
        end
        $display("[TB] test_set_clear done");
    endtask

    task automatic test_back_to_back();
        int w0;
        preload(3'd4, 32'h100);
        w0 = wr_count;
        rsp_ready = 1'b1;
        set_req(OP_RS, 12'h340, 2'd1, 32'h001, 1'b0, 8'h21);
        #1;
        @(posedge clk); #1;
        set_req(OP_RS, 12'h340, 2'd1, 32'h010, 1'b0, 8'h22);
        #1;
        tests_run++;
        if ({req_ready, csr_write_enable, csr_write_data, rsp_data} !== {1'b0, 1'b1, 32'h101, 32'h100}) begin
            tests_failed++;
            $display("FAIL hazard_stall: rdy=%b we=%b wd=%h rsp=%h want 0 1 00000101 00000100",
                     req_ready, csr_write_enable, csr_write_data, rsp_data);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({req_ready, rsp_valid, csr_read_data} !== {1'b1, 1'b0, 32'h101}) begin
            tests_failed++;
            $display("FAIL hazard_retry: rdy=%b v=%b rd=%h want 1 0 00000101",
                     req_ready, rsp_valid, csr_read_data);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        tests_run++;
        if ({rsp_valid, rsp_data, csr_write_data} !== {1'b1, 32'h101, 32'h111}) begin
            tests_failed++;
            $display("FAIL hazard_second: v=%b rsp=%h wd=%h want 1 00000101 00000111",
                     rsp_valid, rsp_data, csr_write_data);
        end
        @(posedge clk); #1;
        tests_run++;
        if (wr_count - w0 != 2) begin
            tests_failed++;
            $display("FAIL hazard_write_count: got %0d want 2", wr_count - w0);
        end

        preload(3'd2, 32'h22);
        preload(3'd6, 32'h66);
        w0 = wr_count;
        set_req(OP_RW, 12'h342, 2'd0, 32'hA, 1'b0, 8'h31);
        #1;
        @(posedge clk); #1;
        set_req(OP_RW, 12'h342, 2'd1, 32'hB, 1'b0, 8'h32);
        #1;
        tests_run++;
        if ({req_ready, rsp_data, csr_write_wid, csr_write_data} !== {1'b1, 32'h22, 2'd0, 32'hA}) begin
            tests_failed++;
            $display("FAIL diffwid_nostall: rdy=%b rsp=%h ww=%0d wd=%h want 1 00000022 0 0000000a",
                     req_ready, rsp_data, csr_write_wid, csr_write_data);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        tests_run++;
        if ({csr_write_enable, rsp_data, csr_write_wid, csr_write_data} !== {1'b1, 32'h66, 2'd1, 32'hB}) begin
            tests_failed++;
            $display("FAIL diffwid_second: we=%b rsp=%h ww=%0d wd=%h want 1 00000066 1 0000000b",
                     csr_write_enable, rsp_data, csr_write_wid, csr_write_data);
        end
        @(posedge clk); #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || wr_count - w0 != 2) begin
            tests_failed++;
            $display("FAIL diffwid_drain: v=%b writes=%0d want 0 2", rsp_valid, wr_count - w0);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_backpressure();
        int w0;
        preload(3'd1, 32'h77);
        preload(3'd3, 32'h33);
        w0 = wr_count;
        rsp_ready = 1'b0;
        set_req(OP_RW, 12'h341, 2'd0, 32'h99, 1'b0, 8'h41);
        #1;
        @(posedge clk); #1;
        set_req(OP_RW, 12'h343, 2'd0, 32'h5, 1'b0, 8'h42);
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if ({rsp_valid, rsp_data, req_ready} !== {1'b1, 32'h77, 1'b0}) begin
                tests_failed++;
                $display("FAIL bp_hold cycle %0d: v=%b rsp=%h rdy=%b want 1 00000077 0",
                         i, rsp_valid, rsp_data, req_ready);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (wr_count - w0 != 1) begin
            tests_failed++;
            $display("FAIL bp_single_write: got %0d want 1", wr_count - w0);
        end
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if ({req_ready, rsp_data} !== {1'b1, 32'h77}) begin
            tests_failed++;
            $display("FAIL bp_release: rdy=%b rsp=%h want 1 00000077", req_ready, rsp_data);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        tests_run++;
        if ({rsp_data, csr_write_enable, csr_write_data} !== {32'h33, 1'b1, 32'h5}) begin
            tests_failed++;
            $display("FAIL bp_next: rsp=%h we=%b wd=%h want 00000033 1 00000005",
                     rsp_data, csr_write_enable, csr_write_data);
        end
        @(posedge clk); #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || wr_count - w0 != 2) begin
            tests_failed++;
            $display("FAIL bp_drain: v=%b writes=%0d want 0 2", rsp_valid, wr_count - w0);
        end
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_reset_mid();
        int w0;
        preload(3'd0, 32'h10);
        w0 = wr_count;
        rsp_ready = 1'b1;
        set_req(OP_RW, 12'h340, 2'd0, 32'h20, 1'b0, 8'h51);
        #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({csr_write_enable, rsp_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rstmid_during: we=%b v=%b want 0 0", csr_write_enable, rsp_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({rsp_valid, csr_write_enable, busy} !== 3'b000 || wr_count - w0 != 0) begin
            tests_failed++;
            $display("FAIL rstmid_after: v=%b we=%b busy=%b writes=%0d want 0 0 0 0",
                     rsp_valid, csr_write_enable, busy, wr_count - w0);
        end
        tests_run++;
        if (csr_read_data !== 32'h10) begin
            tests_failed++;
            $display("FAIL rstmid_csr_kept: got %h want 00000010", csr_read_data);
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        req_valid = 1'b0; req_op = OP_RW; req_addr = '0; req_wid = '0;
        req_src = '0; req_no_write = 1'b0; req_uuid = '0; rsp_ready = 1'b1;
        reset = 1'b1;
        test_reset();
        test_rw();
        test_set_clear();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
